serial_tx: RTL and testbench
============================

SERIAL_TX -- requirements
Module: serial_tx

Interface
REQ-001 Parameter DATA_W, default 8, payload bits per frame (legal range 1..16).
REQ-002 Parameter CLKS_PER_BIT, default 4, clock cycles each serial bit is held (legal range 1..65535).
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 data  input  DATA_W  parallel word to transmit; sampled only on handshake.
REQ-007 valid  input  1  data holds a word to send.
REQ-008 ready  output  1  block can accept a word this cycle.
REQ-009 o  output  1  registered serial line; idle level 1.
REQ-010 busy  output  1  frame in progress.

Function
REQ-011 Handshake SHALL occur on a rising edge where valid=1 and ready=1; data is latched on that edge.
REQ-012 ready SHALL be 1 only in IDLE, as a registered output; it deasserts on the handshake edge.
REQ-013 States SHALL be IDLE, START, DATA, STOP.
- IDLE->START on handshake.
- START->DATA after CLKS_PER_BIT cycles.
- DATA->STOP after DATA_W bits.
- STOP->IDLE after CLKS_PER_BIT cycles.
REQ-014 o SHALL be 1 in IDLE and STOP, 0 in START, and the current data bit in DATA.
REQ-015 Data bits SHALL be sent LSB first, each held exactly CLKS_PER_BIT cycles.
REQ-016 The START bit SHALL appear on o in the cycle after the handshake edge (latency 1).
REQ-017 A frame SHALL occupy exactly (DATA_W+2)*CLKS_PER_BIT cycles of o.
REQ-018 busy SHALL be 1 in START, DATA, STOP and 0 in IDLE.
REQ-019 After STOP, ready SHALL be 1 for at least one cycle before the next handshake. Minimum frame spacing is one idle cycle.
REQ-020 Changes on data or valid while busy SHALL NOT affect the frame in flight.
REQ-021 With CLKS_PER_BIT=1, each bit SHALL last exactly one cycle, with no skipped or doubled bits.
REQ-022 The bit-time counter SHALL be ceil(log2(CLKS_PER_BIT)) bits wide, minimum 1, and SHALL wrap to 0 at CLKS_PER_BIT-1.
REQ-023 The bit index SHALL be ceil(log2(DATA_W)) bits wide, minimum 1, and SHALL NOT exceed DATA_W-1.

Reset
REQ-024 On rst=1, asynchronously: state=IDLE, o=1, ready=0, busy=0, counters and shift register cleared.
REQ-025 On the first rising edge after rst deasserts, ready SHALL become 1.
REQ-026 Reset asserted mid-frame SHALL abort the frame, force o=1 immediately, and discard the latched word.
REQ-027 A handshake SHALL NOT be accepted on any edge where rst=1.

Structure
REQ-028 Shared package serial_pkg SHALL hold:
- the state encoding (IDLE=0, START=1, DATA=2, STOP=3);
- default constants DATA_W_DEF=8 and CLKS_PER_BIT_DEF=4.
The future matching receiver reuses this package.
REQ-029 One sub-module, bit_timer, SHALL implement the CLKS_PER_BIT cycle counter. It takes clk, rst, and an enable, and produces a one-cycle tick at the end of each bit time.
REQ-030 The parent SHALL own the state machine, shift register and bit index. No combinational path from inputs to o.

Verification
REQ-031 Reset release, valid=0:
- o=1, busy=0, ready=1 from the first edge after rst drops;
- ready stays 1 for 100 cycles with no activity.
REQ-032 DATA_W=8, CLKS_PER_BIT=4, send 0xA5, one handshake:
- o = 0, then bits 1,0,1,0,0,1,0,1 (LSB first), then 1;
- each bit held 4 cycles, 40 cycles total;
- ready returns 1 the cycle after STOP ends.
REQ-033 valid held high continuously with 0x00 then 0xFF:
- two complete frames;
- exactly one idle cycle (o=1, ready=1) between them;
- second word latched only at its own handshake.
REQ-034 data toggled every cycle during a 0x3C frame:
- serial output still equals 0x3C.
REQ-035 rst pulsed for 1 cycle at cycle 17 of a frame:
- o=1 asynchronously, busy=0;
- ready=1 the edge after release;
- no remaining bits emitted.
REQ-036 CLKS_PER_BIT=1, DATA_W=8, send 0x81:
- o sequence 0,1,0,0,0,0,0,0,1,1 over 10 consecutive cycles.

Source files
------------

// File: rtl/serial_pkg.sv
// serial_pkg -- definitions shared by the serial transmitter and the matching
// receiver: FSM state encoding, default frame parameters and a width helper.
package serial_pkg;

  localparam int DATA_W_DEF       = 8;
  localparam int CLKS_PER_BIT_DEF = 4;

  // Frame state encoding; kept as plain constants so the receiver and any
  // older tooling decode the same 2-bit values.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  // Counter width for a range of n values, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_tx_if.sv
// serial_tx_if -- word handshake plus serial line of the transmitter.
//   data  : parallel word, sampled only on the handshake edge
//   valid : data holds a word to send
//   ready : transmitter can accept a word this cycle
//   o     : registered serial line, idles high
//   busy  : frame in progress
// master = word producer, slave = transmitter.
interface serial_tx_if import serial_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF
);
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              ready;
  logic              o;
  logic              busy;

  modport master (output data, output valid, input ready, input o, input busy);
  modport slave  (input data, input valid, output ready, output o, output busy);
endinterface

// File: rtl/bit_timer.sv
// bit_timer -- counts the clock cycles of one serial bit time.
//   clk, rst : clock, asynchronous active-high reset
//   en       : count while high; held at zero while low
//   tick     : one-cycle pulse in the last cycle of each bit time
module bit_timer import serial_pkg::*; #(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);
  localparam int            CW   = clog2_min1(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  // With CLKS_PER_BIT=1 LAST is 0, so tick follows en every cycle and each
  // bit lasts exactly one clock.
  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              cnt <= '0;
    else if (!en || tick) cnt <= '0;
    else                  cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/serial_tx.sv
// serial_tx -- parallel-to-serial transmitter, one frame per accepted word:
// start bit (0), DATA_W data bits LSB first, stop bit (1), each held
// CLKS_PER_BIT cycles.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : serial_tx_if slave (data/valid/ready handshake, o, busy)
// All outputs are registered; nothing on the input side reaches o within
// the same cycle.
module serial_tx import serial_pkg::*; #(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic         clk,
  input  logic         rst,
  serial_tx_if.slave   bus
);
  localparam int            IW       = clog2_min1(DATA_W);
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_W - 1);

  logic [1:0]        state;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shnext;
  logic [IW-1:0]     bit_idx;
  logic              ready_q;
  logic              busy_q;
  logic              o_q;
  logic              tick;
  logic              hs;
  logic              timer_en;

  // ready_q is only ever set in IDLE, and is 0 on the first IDLE cycle after
  // reset, so no handshake can be taken during or straight out of reset.
  assign hs       = (state == ST_IDLE) && ready_q && bus.valid;
  assign timer_en = (state != ST_IDLE);
  // Separate net so a 1-bit payload does not need an out-of-range select.
  assign shnext   = shreg >> 1;

  bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .en   (timer_en),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      shreg   <= '0;
      bit_idx <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      o_q     <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (hs) begin
            state   <= ST_START;
            shreg   <= bus.data;
            bit_idx <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            o_q     <= 1'b0;
          end else begin
            ready_q <= 1'b1;
          end
        end
        ST_START: begin
          if (tick) begin
            state <= ST_DATA;
            o_q   <= shreg[0];
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (bit_idx == LAST_BIT) begin
              state <= ST_STOP;
              o_q   <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              shreg   <= shnext;
              o_q     <= shnext[0];
            end
          end
        end
        ST_STOP: begin
          if (tick) begin
            state   <= ST_IDLE;
            shreg   <= '0;
            bit_idx <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state   <= ST_IDLE;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
          o_q     <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ready = ready_q;
  assign bus.busy  = busy_q;
  assign bus.o     = o_q;
endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx -- two transmitters (CLKS_PER_BIT=4 and =1) checked every
// cycle against a frame-level model, plus directed literal checks.
module tb_serial_tx;
  import serial_pkg::*;

  localparam int W = 8;
  localparam int CPB [2] = '{4, 1};

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  serial_tx_if #(.DATA_W(W)) bus_a ();
  serial_tx_if #(.DATA_W(W)) bus_b ();

  serial_tx #(.DATA_W(W), .CLKS_PER_BIT(4)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  serial_tx #(.DATA_W(W), .CLKS_PER_BIT(1)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  logic         d_o [2], d_busy [2], d_rdy [2], d_val [2];
  logic [W-1:0] d_dat [2];
  assign d_o[0] = bus_a.o;     assign d_o[1] = bus_b.o;
  assign d_busy[0] = bus_a.busy; assign d_busy[1] = bus_b.busy;
  assign d_rdy[0] = bus_a.ready; assign d_rdy[1] = bus_b.ready;
  assign d_val[0] = bus_a.valid; assign d_val[1] = bus_b.valid;
  assign d_dat[0] = bus_a.data;  assign d_dat[1] = bus_b.data;

  task automatic chk(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Frame bit number idx: 0 = start, 1..W = payload LSB first, W+1 = stop.
  function automatic logic fbit(input logic [W-1:0] w, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= W) return w[idx-1];
    return 1'b1;
  endfunction

  // Model: a frame is the (W+2)*CPB cycles following an accepted word; t
  // counts those cycles. Ready is high whenever no frame runs, except the
  // first cycle out of reset.
  bit           m_act [2] = '{1'b0, 1'b0};
  bit           m_rdy [2] = '{1'b0, 1'b0};
  int           m_t   [2] = '{0, 0};
  logic [W-1:0] m_word [2];

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_act[k] <= 1'b0;
        m_rdy[k] <= 1'b0;
        m_t[k]   <= 0;
      end else if (m_act[k]) begin
        if (m_t[k] == (W + 2) * CPB[k] - 1) begin
          m_act[k] <= 1'b0;
          m_rdy[k] <= 1'b1;
        end else begin
          m_t[k] <= m_t[k] + 1;
        end
      end else if (m_rdy[k] && d_val[k] === 1'b1) begin
        m_act[k]  <= 1'b1;
        m_t[k]    <= 0;
        m_word[k] <= d_dat[k];
        m_rdy[k]  <= 1'b0;
      end else begin
        m_rdy[k] <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        logic eo;
        eo = m_act[k] ? fbit(m_word[k], m_t[k] / CPB[k]) : 1'b1;
        chk($sformatf("model_o[%0d]", k), d_o[k], eo);
        chk($sformatf("model_busy[%0d]", k), d_busy[k], m_act[k]);
        chk($sformatf("model_ready[%0d]", k), d_rdy[k], m_rdy[k]);
      end
    end
  end

  // Starting at the first frame-cycle negedge of dut_a, sample the middle of
  // each payload bit. mode 1 scrambles data every cycle, mode 2 switches
  // data to 0xFF partway through.
  task automatic capture_a(input int mode, output logic [W-1:0] w, output int busy_n);
    w = '0;
    busy_n = 0;
    for (int i = 0; i < 40; i++) begin
      if (i > 0) @(negedge clk);
      if (mode == 1) bus_a.data = W'($urandom);
      if (mode == 2 && i == 10) bus_a.data = 8'hFF;
      if (i / 4 >= 1 && i / 4 <= W && i % 4 == 1) w[i/4-1] = bus_a.o;
      if (bus_a.busy) busy_n++;
    end
  endtask

  initial begin
    logic [9:0]   pat;
    logic [W-1:0] w;
    int           n;
    bus_a.valid = 1'b0; bus_a.data = '0;
    bus_b.valid = 1'b0; bus_b.data = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_o", bus_a.o, 1'b1);
    chk("rst_ready", bus_a.ready, 1'b0);
    chk("rst_busy", bus_a.busy, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_first_edge_a", bus_a.ready, 1'b1);
    chk("ready_first_edge_b", bus_b.ready, 1'b1);

    // Idle for 100 cycles.
    n = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus_a.ready && bus_a.o && !bus_a.busy) n++;
    end
    chki("idle_ready_cycles", n, 100);

    // 0xA5 with CLKS_PER_BIT=4.
    pat = 10'b1101001010;
    bus_a.data = 8'hA5; bus_a.valid = 1'b1;
    @(negedge clk);
    bus_a.valid = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (i > 0) @(negedge clk);
      chk($sformatf("a5_o_cyc%0d", i + 1), bus_a.o, pat[i/4]);
      if (bus_a.busy) n++;
    end
    chki("a5_busy_cycles", n, 40);
    @(negedge clk);
    chk("a5_ready_after_stop", bus_a.ready, 1'b1);

    // valid held high: 0x00 then 0xFF with exactly one idle cycle between.
    bus_a.data = 8'h00; bus_a.valid = 1'b1;
    @(negedge clk);
    capture_a(2, w, n);
    chki("b2b_word1", int'(w), 8'h00);
    chki("b2b_busy1", n, 40);
    @(negedge clk);
    chk("gap_ready", bus_a.ready, 1'b1);
    chk("gap_o", bus_a.o, 1'b1);
    @(negedge clk);
    chk("gap_one_cycle_busy", bus_a.busy, 1'b1);
    chk("gap_one_cycle_o", bus_a.o, 1'b0);
    bus_a.valid = 1'b0;
    capture_a(0, w, n);
    chki("b2b_word2", int'(w), 8'hFF);
    @(negedge clk);

    // 0x3C with data scrambled every cycle.
    bus_a.data = 8'h3C; bus_a.valid = 1'b1;
    @(negedge clk);
    bus_a.valid = 1'b0;
    capture_a(1, w, n);
    chki("scramble_word", int'(w), 8'h3C);
    @(negedge clk);

    // Reset pulse at frame cycle 17 (payload bit 3 of 0xA5, a 0).
    bus_a.data = 8'hA5; bus_a.valid = 1'b1;
    @(negedge clk);
    bus_a.valid = 1'b0;
    repeat (16) @(negedge clk);
    chk("pre_rst_o", bus_a.o, 1'b0);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_o", bus_a.o, 1'b1);
    chk("async_rst_busy", bus_a.busy, 1'b0);
    @(negedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_rst_pulse", bus_a.ready, 1'b1);
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (!bus_a.o || bus_a.busy) n++;
    end
    chki("no_bits_after_rst", n, 0);

    // 0x81 with CLKS_PER_BIT=1.
    pat = 10'b1100000010;
    bus_b.data = 8'h81; bus_b.valid = 1'b1;
    @(negedge clk);
    bus_b.valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      chk($sformatf("x81_o_cyc%0d", i + 1), bus_b.o, pat[i]);
    end
    @(negedge clk);
    chk("x81_ready_after", bus_b.ready, 1'b1);

    // Random traffic on both transmitters.
    repeat (3000) begin
      @(negedge clk);
      bus_a.valid = ($urandom_range(0, 3) != 0);
      bus_a.data  = W'($urandom);
      bus_b.valid = ($urandom_range(0, 3) != 0);
      bus_b.data  = W'($urandom);
    end
    bus_a.valid = 1'b0;
    bus_b.valid = 1'b0;
    repeat (50) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
